// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, default sizes and the byte-lane merge helper for data_memory_ctrl.
//   dmem_state_t : controller state (INIT sweep, RUN)
//   DMEM_*       : default parameter values for the controller
//   lane_merge() : old word, new word, lane mask -> merged word (lane i = bits [8i+7:8i])
package dmem_pkg;

   typedef enum logic [0:0] {
      INIT,
      RUN
   } dmem_state_t;

   localparam int unsigned DMEM_DATA_W = 32;
   localparam int unsigned DMEM_DEPTH  = 16;
   localparam int unsigned DMEM_ADDR_W = 16;

   // Widest word the merge helper handles; callers cast in and out of this width.
   localparam int unsigned DMEM_MAX_W  = 1024;

   function automatic logic [DMEM_MAX_W-1:0] lane_merge(
      input logic [DMEM_MAX_W-1:0]   old_word,
      input logic [DMEM_MAX_W-1:0]   new_word,
      input logic [DMEM_MAX_W/8-1:0] mask
   );
      logic [DMEM_MAX_W-1:0] merged;
      merged = old_word;
      for (int i = 0; i < int'(DMEM_MAX_W / 8); i++) begin
         if (mask[i]) begin
            merged[i*8 +: 8] = new_word[i*8 +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with a synchronous lane-masked write port and a synchronous read port.
//   i_clk, i_rst : clock, asynchronous active-high reset (clears the read register only)
//   i_we, i_waddr, i_wdata, i_wmask : write word i_waddr, only lanes whose mask bit is set
//   i_re, i_raddr : capture word i_raddr into o_rdata on the rising edge
//   o_rdata      : registered read data, held until the next read
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = DMEM_DATA_W,
   parameter int unsigned DEPTH  = DMEM_DEPTH,
   parameter int unsigned IDX_W  = 4,
   parameter int unsigned NB     = (DATA_W + 7) / 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [NB-1:0]     i_wmask,
   input  logic              i_re,
   input  logic [IDX_W-1:0]  i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= DATA_W'(lane_merge(DMEM_MAX_W'(r_mem[i_waddr]),
                                              DMEM_MAX_W'(i_wdata),
                                              (DMEM_MAX_W/8)'(i_wmask)));
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: word-addressed RAM with valid/ready request and response ports and a
// post-reset sweep that writes INIT_VALUE to every word before requests are accepted.
//   CLOCK_50, RESET     : clock, asynchronous active-high reset
//   Mem_req_valid/ready : request handshake; CNTRL_write_en selects write (1) or read (0)
//   Mem_addr            : word address, compared against DEPTH at full width
//   RF_Rd_data          : write data
//   Mem_byte_en         : write lane mask (only when DMEM_BYTE_MASK_EN is defined)
//   Mem_resp_valid/ready: read response handshake
//   Mem_data            : read data (0 for an out-of-range read)
//   Mem_addr_err        : response was for an out-of-range address
//   Mem_init_done       : init sweep complete
// Optional feature macro: DMEM_BYTE_MASK_EN.
module data_memory_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned       DATA_W     = DMEM_DATA_W,
   parameter int unsigned       DEPTH      = DMEM_DEPTH,
   parameter int unsigned       ADDR_W     = DMEM_ADDR_W,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
   input  logic              CLOCK_50,
   input  logic              RESET,
   input  logic              Mem_req_valid,
   output logic              Mem_req_ready,
   input  logic              CNTRL_write_en,
   input  logic [ADDR_W-1:0] Mem_addr,
   input  logic [DATA_W-1:0] RF_Rd_data,
`ifdef DMEM_BYTE_MASK_EN
   input  logic [DATA_W/8-1:0] Mem_byte_en,
`endif
   output logic              Mem_resp_valid,
   input  logic              Mem_resp_ready,
   output logic [DATA_W-1:0] Mem_data,
   output logic              Mem_addr_err,
   output logic              Mem_init_done
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned NB    = (DATA_W + 7) / 8;

   dmem_state_t       r_state, w_state_d;
   logic [IDX_W-1:0]  r_cnt, w_cnt_d;
   logic              r_resp_valid;
   logic              r_err;

   logic              w_ready, w_accept, w_wr_acc, w_rd_acc, w_in_range;
   logic [ADDR_W:0]   w_addr_ext;
   logic [NB-1:0]     w_req_mask;
   logic              w_we;
   logic [IDX_W-1:0]  w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic [NB-1:0]     w_wmask;
   logic [DATA_W-1:0] w_rdata;

   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   assign w_addr_ext = {1'b0, Mem_addr};
   assign w_in_range = (w_addr_ext < (ADDR_W + 1)'(DEPTH));

   assign w_ready  = (r_state == RUN) && (!r_resp_valid || Mem_resp_ready);
   assign w_accept = Mem_req_valid && w_ready;
   assign w_wr_acc = w_accept && CNTRL_write_en;
   assign w_rd_acc = w_accept && !CNTRL_write_en;

`ifdef DMEM_BYTE_MASK_EN
   assign w_req_mask = Mem_byte_en;
`else
   assign w_req_mask = '1;
`endif

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_we      = 1'b0;
      w_waddr   = Mem_addr[IDX_W-1:0];
      w_wdata   = RF_Rd_data;
      w_wmask   = w_req_mask;
      unique case (r_state)
         INIT: begin
            // Sweep writes ignore the request mask and fill whole words.
            w_we    = 1'b1;
            w_waddr = r_cnt;
            w_wdata = INIT_VALUE;
            w_wmask = '1;
            if (r_cnt == IDX_W'(DEPTH - 1)) begin
               w_state_d = RUN;
            end else begin
               w_cnt_d = r_cnt + IDX_W'(1);
            end
         end
         RUN: begin
            w_we = w_wr_acc && w_in_range;
         end
         default: w_state_d = INIT;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         r_state      <= INIT;
         r_cnt        <= '0;
         r_resp_valid <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         if (w_rd_acc) begin
            r_resp_valid <= 1'b1;
            r_err        <= !w_in_range;
         end else if (Mem_resp_ready) begin
            r_resp_valid <= 1'b0;
         end
      end
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W),
      .NB     (NB)
   ) u_array (
      .i_clk   (CLOCK_50),
      .i_rst   (RESET),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_wmask (w_wmask),
      .i_re    (w_rd_acc && w_in_range),
      .i_raddr (Mem_addr[IDX_W-1:0]),
      .o_rdata (w_rdata)
   );

   assign Mem_req_ready  = w_ready;
   assign Mem_resp_valid = r_resp_valid;
   assign Mem_addr_err   = r_err;
   // An out-of-range read leaves the array read register untouched, so force zero here.
   assign Mem_data       = r_err ? '0 : w_rdata;
   assign Mem_init_done  = (r_state == RUN);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed and randomized checks of data_memory_ctrl against an array model.
module tb_data_memory_ctrl;

   localparam int unsigned DP = 16;

   logic        CLOCK_50 = 1'b0;
   logic        RESET = 1'b0;
   logic        Mem_req_valid;
   logic        Mem_req_ready;
   logic        CNTRL_write_en;
   logic [15:0] Mem_addr;
   logic [31:0] RF_Rd_data;
`ifdef DMEM_BYTE_MASK_EN
   logic [3:0]  Mem_byte_en;
`endif
   logic        Mem_resp_valid;
   logic        Mem_resp_ready;
   logic [31:0] Mem_data;
   logic        Mem_addr_err;
   logic        Mem_init_done;

   logic [31:0] ref_mem [DP];
   int          n_checks = 0;
   int          n_errors = 0;

   data_memory_ctrl dut (
      .CLOCK_50       (CLOCK_50),
      .RESET          (RESET),
      .Mem_req_valid  (Mem_req_valid),
      .Mem_req_ready  (Mem_req_ready),
      .CNTRL_write_en (CNTRL_write_en),
      .Mem_addr       (Mem_addr),
      .RF_Rd_data     (RF_Rd_data),
`ifdef DMEM_BYTE_MASK_EN
      .Mem_byte_en    (Mem_byte_en),
`endif
      .Mem_resp_valid (Mem_resp_valid),
      .Mem_resp_ready (Mem_resp_ready),
      .Mem_data       (Mem_data),
      .Mem_addr_err   (Mem_addr_err),
      .Mem_init_done  (Mem_init_done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(input logic [15:0] a);
      return (a < 16'(DP)) ? ref_mem[a[3:0]] : 32'h0;
   endfunction

   function automatic logic exp_err(input logic [15:0] a);
      return (a >= 16'(DP));
   endfunction

   task automatic clear_model();
      for (int i = 0; i < int'(DP); i++) ref_mem[i] = 32'h0;
   endtask

   // Counts cycles from reset release until init done; request port must stay closed meanwhile.
   task automatic sweep(input string tag);
      int k;
      logic rdy_seen;
      k = 0;
      rdy_seen = 1'b0;
      while (Mem_init_done !== 1'b1 && k < 64) begin
         if (Mem_req_ready !== 1'b0) rdy_seen = 1'b1;
         step();
         k++;
      end
      chk({tag, "_len"}, 64'(k), 64'(DP));
      chk({tag, "_ready_low"}, 64'(rdy_seen), 64'h0);
   endtask

   task automatic wait_ready(input string tag);
      int k;
      k = 0;
      #1;
      while (Mem_req_ready !== 1'b1 && k < 30) begin
         step();
         k++;
      end
      chk({tag, "_ready"}, 64'(Mem_req_ready), 64'h1);
   endtask

   task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
      Mem_req_valid  = 1'b1;
      CNTRL_write_en = 1'b1;
      Mem_addr       = a;
      RF_Rd_data     = d;
`ifdef DMEM_BYTE_MASK_EN
      Mem_byte_en    = m;
`endif
      wait_ready("wr");
      step();
      Mem_req_valid  = 1'b0;
      CNTRL_write_en = 1'b0;
      if (a < 16'(DP)) begin
         for (int b = 0; b < 4; b++) begin
`ifdef DMEM_BYTE_MASK_EN
            if (m[b]) ref_mem[a[3:0]][b*8 +: 8] = d[b*8 +: 8];
`else
            ref_mem[a[3:0]][b*8 +: 8] = d[b*8 +: 8];
`endif
         end
      end
      chk("wr_no_resp", 64'(Mem_resp_valid), 64'h0);
   endtask

   // Read with an optional stall of 'stall' cycles holding Mem_resp_ready low.
   task automatic do_read(input logic [15:0] a, input int stall);
      logic [31:0] ed;
      logic ee;
      ed = exp_data(a);
      ee = exp_err(a);
      Mem_req_valid  = 1'b1;
      CNTRL_write_en = 1'b0;
      Mem_addr       = a;
      wait_ready("rd");
      step();
      Mem_req_valid = 1'b0;
      chk("rd_valid", 64'(Mem_resp_valid), 64'h1);
      chk("rd_data", 64'(Mem_data), 64'(ed));
      chk("rd_err", 64'(Mem_addr_err), 64'(ee));
      if (stall > 0) begin
         Mem_resp_ready = 1'b0;
         for (int s = 0; s < stall; s++) begin
            step();
            chk("stall_valid", 64'(Mem_resp_valid), 64'h1);
            chk("stall_data", 64'(Mem_data), 64'(ed));
            chk("stall_err", 64'(Mem_addr_err), 64'(ee));
         end
         Mem_resp_ready = 1'b1;
      end
   endtask

   initial begin
      logic [15:0] a;
      logic [31:0] d;
      logic [31:0] last;

      Mem_req_valid  = 1'b0;
      CNTRL_write_en = 1'b0;
      Mem_addr       = '0;
      RF_Rd_data     = '0;
      Mem_resp_ready = 1'b1;
`ifdef DMEM_BYTE_MASK_EN
      Mem_byte_en    = 4'hF;
`endif
      clear_model();

      // Reset values
      #1 RESET = 1'b1;
      #11;
      chk("rst_req_ready", 64'(Mem_req_ready), 64'h0);
      chk("rst_resp_valid", 64'(Mem_resp_valid), 64'h0);
      chk("rst_data", 64'(Mem_data), 64'h0);
      chk("rst_err", 64'(Mem_addr_err), 64'h0);
      chk("rst_init_done", 64'(Mem_init_done), 64'h0);
      @(posedge CLOCK_50);
      #1 RESET = 1'b0;
      sweep("sweep1");

      for (int i = 0; i < int'(DP); i++) do_read(16'(i), 0);

      // Write then read the same word on the next cycle
      do_write(16'd5, 32'hDEADBEEF, 4'hF);
      do_read(16'd5, 0);
      chk("w5_const", 64'(Mem_data), 64'hDEADBEEF);

      // Stalled response with a write request pending behind it
      do_write(16'd3, 32'h33333333, 4'hF);
      Mem_req_valid  = 1'b1;
      CNTRL_write_en = 1'b0;
      Mem_addr       = 16'd3;
      wait_ready("stall_rd");
      step();
      Mem_resp_ready = 1'b0;
      CNTRL_write_en = 1'b1;
      RF_Rd_data     = 32'h0BADF00D;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("hold_req_ready", 64'(Mem_req_ready), 64'h0);
         chk("hold_valid", 64'(Mem_resp_valid), 64'h1);
         chk("hold_data", 64'(Mem_data), 64'h33333333);
         step();
      end
      Mem_resp_ready = 1'b1;
      #1;
      chk("release_ready", 64'(Mem_req_ready), 64'h1);
      step();
      Mem_req_valid  = 1'b0;
      CNTRL_write_en = 1'b0;
      ref_mem[3] = 32'h0BADF00D;
      chk("release_retire", 64'(Mem_resp_valid), 64'h0);
      do_read(16'd3, 0);

      // Out-of-range writes are dropped; reads flag an error with zero data
      do_write(16'd16, 32'h12345678, 4'hF);
      do_write(16'h8005, 32'h5555AAAA, 4'hF);
      do_write(16'hFFFF, 32'hFFFFFFFF, 4'hF);
      do_read(16'd16, 0);
      chk("oor_data_const", 64'(Mem_data), 64'h0);
      chk("oor_err_const", 64'(Mem_addr_err), 64'h1);
      do_read(16'h8005, 2);
      for (int i = 0; i < int'(DP); i++) do_read(16'(i), 0);

`ifdef DMEM_BYTE_MASK_EN
      do_write(16'd2, 32'hAABBCCDD, 4'hF);
      do_write(16'd2, 32'h11223344, 4'b0101);
      do_read(16'd2, 0);
      chk("mask_const", 64'(Mem_data), 64'hAA22CC44);
      do_write(16'd2, 32'h99999999, 4'b0000);
      do_read(16'd2, 0);
`endif

      // Back-to-back reads: response stays valid, one read per cycle
      last = 32'h0;
      Mem_req_valid  = 1'b1;
      CNTRL_write_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a = 16'($urandom_range(0, 19));
         Mem_addr = a;
         #1;
         chk("b2b_ready", 64'(Mem_req_ready), 64'h1);
         step();
         last = exp_data(a);
         chk("b2b_valid", 64'(Mem_resp_valid), 64'h1);
         chk("b2b_data", 64'(Mem_data), 64'(last));
         chk("b2b_err", 64'(Mem_addr_err), 64'(exp_err(a)));
      end
      Mem_req_valid = 1'b0;
      step();
      chk("b2b_retire", 64'(Mem_resp_valid), 64'h0);
      chk("b2b_keep_data", 64'(Mem_data), 64'(last));

      // Randomized mix against the model
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 9) == 0) a = 16'($urandom);
         else a = 16'($urandom_range(0, 17));
         d = $urandom;
         if ($urandom_range(0, 2) == 0) do_write(a, d, 4'($urandom));
         else do_read(a, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      // Reset mid-sweep
      RESET = 1'b1;
      #1;
      chk("rst2_init_done", 64'(Mem_init_done), 64'h0);
      chk("rst2_ready", 64'(Mem_req_ready), 64'h0);
      @(posedge CLOCK_50);
      #1 RESET = 1'b0;
      clear_model();
      for (int i = 0; i < 7; i++) step();
      RESET = 1'b1;
      #1;
      chk("rst3_init_done", 64'(Mem_init_done), 64'h0);
      chk("rst3_data", 64'(Mem_data), 64'h0);
      @(posedge CLOCK_50);
      #1 RESET = 1'b0;
      sweep("sweep_mid");
      for (int i = 0; i < int'(DP); i++) do_read(16'(i), 0);

      // Reset while a response is stalled
      do_write(16'd5, 32'hCAFEF00D, 4'hF);
      Mem_req_valid  = 1'b1;
      CNTRL_write_en = 1'b0;
      Mem_addr       = 16'd5;
      wait_ready("rst_rd");
      step();
      Mem_req_valid  = 1'b0;
      Mem_resp_ready = 1'b0;
      step();
      step();
      chk("pre_rst_valid", 64'(Mem_resp_valid), 64'h1);
      chk("pre_rst_data", 64'(Mem_data), 64'hCAFEF00D);
      #2 RESET = 1'b1;
      #1;
      chk("rst4_valid", 64'(Mem_resp_valid), 64'h0);
      chk("rst4_data", 64'(Mem_data), 64'h0);
      chk("rst4_err", 64'(Mem_addr_err), 64'h0);
      chk("rst4_ready", 64'(Mem_req_ready), 64'h0);
      chk("rst4_init_done", 64'(Mem_init_done), 64'h0);
      @(posedge CLOCK_50);
      #1 RESET = 1'b0;
      Mem_resp_ready = 1'b1;
      clear_model();
      sweep("sweep_stall");
      chk("post_rst_no_resp", 64'(Mem_resp_valid), 64'h0);
      do_read(16'd5, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
